// File: rtl/mbtrain_sb_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mbtrain_sb_responder: MBTRAIN RX sideband start/cal/end responder, N rounds |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mbtrain_sb_responder #(
  parameter int               MSG_W          = 4,
  parameter logic [MSG_W-1:0] START_REQ      = 4'b0001,
  parameter logic [MSG_W-1:0] START_RESP     = 4'b0010,
  parameter logic [MSG_W-1:0] END_REQ        = 4'b0011,
  parameter logic [MSG_W-1:0] END_RESP       = 4'b0100,
  parameter int               CAL_CYCLES     = 8,
  parameter int               TIMEOUT_CYCLES = 4096,
  parameter int               N_ITER         = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic [MSG_W-1:0]              i_decoded_sideband_message,
  input  logic                          i_sideband_valid,
  input  logic                          i_cal_done,
  input  logic                          i_busy_negedge_detected,
  input  logic                          i_valid_tx,
  output logic [MSG_W-1:0]              o_sideband_message,
  output logic                          o_valid_rx,
  output logic                          o_cal_en,
  output logic [$clog2(N_ITER+1)-1:0]   o_iter,
  output logic                          o_test_ack,
  output logic                          o_timeout
);

  localparam int ITER_W  = $clog2(N_ITER + 1);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > CAL_CYCLES) ? TIMEOUT_CYCLES : CAL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CAL_LAST  = CNT_W'(CAL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_SEND_START = 3'd2,
    S_CAL        = 3'd3,
    S_WAIT_END   = 3'd4,
    S_SEND_END   = 3'd5,
    S_DONE       = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start_seen;
  logic             end_seen;
  logic             early_end;
  logic             pending;
  logic             handshake;

  assign handshake = o_valid_rx & i_busy_negedge_detected;
  assign o_cal_en  = (state == S_CAL);

  always_comb begin
    state_nxt = state;
    if (!i_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:       state_nxt = S_WAIT_START;
        S_WAIT_START: begin
          // a request landing on the last timeout cycle still wins
          if (start_seen)            state_nxt = S_SEND_START;
          else if (cnt == TMO_LAST)  state_nxt = S_ERROR;
        end
        S_SEND_START: if (handshake) state_nxt = S_CAL;
        S_CAL:        if (i_cal_done || cnt == CAL_LAST) state_nxt = S_WAIT_END;
        S_WAIT_END: begin
          if (early_end || end_seen) state_nxt = S_SEND_END;
          else if (cnt == TMO_LAST)  state_nxt = S_ERROR;
        end
        S_SEND_END: begin
          if (handshake) state_nxt = (o_iter == ITER_LAST) ? S_DONE : S_WAIT_START;
        end
        default:      state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      cnt                <= '0;
      start_seen         <= 1'b0;
      end_seen           <= 1'b0;
      early_end          <= 1'b0;
      pending            <= 1'b0;
      o_valid_rx         <= 1'b0;
      o_sideband_message <= '0;
      o_iter             <= '0;
      o_test_ack         <= 1'b0;
      o_timeout          <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_seen <= i_sideband_valid && (i_decoded_sideband_message == START_REQ);
      end_seen   <= i_sideband_valid && (i_decoded_sideband_message == END_REQ);

      if (state_nxt != state) cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);

      if (!i_en) begin
        early_end          <= 1'b0;
        pending            <= 1'b0;
        o_valid_rx         <= 1'b0;
        o_sideband_message <= '0;
        o_iter             <= '0;
        o_test_ack         <= 1'b0;
        o_timeout          <= 1'b0;
      end else begin
        // busy negedge closes the transfer and beats a new rise
        if (handshake) begin
          o_valid_rx <= 1'b0;
          pending    <= 1'b0;
        end else if (pending && !i_valid_tx) begin
          o_valid_rx <= 1'b1;
        end

        case (state)
          S_IDLE: begin
            early_end          <= 1'b0;
            o_sideband_message <= '0;
            o_iter             <= '0;
            o_test_ack         <= 1'b0;
            o_timeout          <= 1'b0;
          end
          S_CAL:      if (end_seen) early_end <= 1'b1;
          S_WAIT_END: early_end <= 1'b0;
          S_SEND_END: if (handshake) o_iter <= o_iter + ITER_W'(1);
          default:    ;
        endcase

        if (state_nxt != state) begin
          case (state_nxt)
            S_SEND_START: begin
              o_sideband_message <= START_RESP;
              pending            <= 1'b1;
            end
            S_SEND_END: begin
              o_sideband_message <= END_RESP;
              pending            <= 1'b1;
            end
            S_DONE: begin
              o_test_ack         <= 1'b1;
              o_sideband_message <= '0;
            end
            S_ERROR: begin
              o_timeout          <= 1'b1;
              o_sideband_message <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
